// File: rtl/sad_accum_block.sv
// SAD accumulator: sums five candidates' lane differences over a block, then picks the min.
// Optional macro SAD_ACCUM_CENTER_BIAS_EN lets candidate 2 (M) win ties at the minimum.
module sad_accum_block #(
   parameter int LANES = 7,
   parameter int LINES = 8,
   parameter int SAD_W = 14
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_first,
   input  logic [5*LANES*8-1:0]   diff_in,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2:0]             best_idx,
   output logic [SAD_W-1:0]       best_sad
);

   typedef enum logic [1:0] {IDLE, ACCUM, CMP, DONE} state_t;

   localparam int CNT_W = $clog2(LINES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LINES - 1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       cidx;
   logic [SAD_W-1:0] sad      [5];
   logic [SAD_W-1:0] line_sum [5];
   logic [SAD_W-1:0] cand;
   logic             accept;
   logic             load;
   logic             add;
   logic             take;

   assign in_ready = !rst && (state == IDLE || state == ACCUM);
   assign accept   = in_valid && in_ready;

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         line_sum[k] = '0;
         for (int j = 0; j < LANES; j++) begin
            line_sum[k] = line_sum[k] + SAD_W'(diff_in[(k*LANES+j)*8 +: 8]);
         end
      end
   end

   always_comb begin
      cand = '0;
      for (int k = 0; k < 5; k++) begin
         if (cidx == 3'(k)) cand = sad[k];
      end
   end

   // Candidate 0 seeds the running minimum; later ones must be strictly smaller
   always_comb begin
`ifdef SAD_ACCUM_CENTER_BIAS_EN
      if (cidx == 3'd2) take = (cand <= best_sad);
      else              take = (cand < best_sad);
`else
      take = (cand < best_sad);
`endif
      if (cidx == 3'd0) take = 1'b1;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      add      = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept && in_first) begin
               load     = 1'b1;
               state_nx = (LINES == 1) ? CMP : ACCUM;
            end
         end
         ACCUM: begin
            if (accept && in_first) begin
               load     = 1'b1;
               state_nx = (LINES == 1) ? CMP : ACCUM;
            end else if (accept) begin
               add = 1'b1;
               if (cnt == LAST) state_nx = CMP;
            end
         end
         CMP: begin
            if (cidx == 3'd4) state_nx = DONE;
         end
         DONE: begin
            if (out_ready) state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         cidx      <= '0;
         out_valid <= 1'b0;
         best_idx  <= '0;
         best_sad  <= '0;
         for (int k = 0; k < 5; k++) sad[k] <= '0;
      end else begin
         if (load) begin
            cnt <= CNT_W'(1);
            for (int k = 0; k < 5; k++) sad[k] <= line_sum[k];
         end else if (add) begin
            cnt <= cnt + CNT_W'(1);
            for (int k = 0; k < 5; k++) sad[k] <= sad[k] + line_sum[k];
         end
         if (state == CMP) begin
            if (take) begin
               best_sad <= cand;
               best_idx <= cidx;
            end
            cidx <= (cidx == 3'd4) ? 3'd0 : cidx + 3'd1;
            if (cidx == 3'd4) out_valid <= 1'b1;
         end
         if (state == DONE && out_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sad_accum_block.sv
// Randomized bench for sad_accum_block against a plain-arithmetic SAD/min model.
module tb_sad_accum_block;

   localparam int LANES = 7;
   localparam int LINES = 8;
   localparam int SAD_W = 14;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_first;
   logic [5*LANES*8-1:0] diff_in;
   logic                 in_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [2:0]           best_idx;
   logic [SAD_W-1:0]     best_sad;

   int n_chk  = 0;
   int n_fail = 0;

   int ln      [5][LANES];
   int exp_sad [5];

   sad_accum_block #(.LANES(LANES), .LINES(LINES), .SAD_W(SAD_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .diff_in   (diff_in),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .best_idx  (best_idx),
      .best_sad  (best_sad)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int a0, input int a1, input int a2, input int a3, input int a4);
      int v [5];
      v = '{a0, a1, a2, a3, a4};
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < LANES; j++) ln[k][j] = v[k];
   endtask

   task automatic fill_rand(input int maxv);
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < LANES; j++) ln[k][j] = $urandom_range(0, maxv);
   endtask

   // Block SAD = sum over lines of sum over lanes; a first line restarts it
   task automatic model_line(input bit first);
      for (int k = 0; k < 5; k++) begin
         int s = 0;
         for (int j = 0; j < LANES; j++) s += ln[k][j];
         exp_sad[k] = first ? s : exp_sad[k] + s;
      end
   endtask

   task automatic exp_best(output int idx, output int s);
      s = exp_sad[0];
      idx = 0;
      for (int k = 1; k < 5; k++) if (exp_sad[k] < s) s = exp_sad[k];
      for (int k = 4; k >= 0; k--) if (exp_sad[k] == s) idx = k;
`ifdef SAD_ACCUM_CENTER_BIAS_EN
      if (exp_sad[2] == s) idx = 2;
`endif
   endtask

   task automatic send_line(input bit first, input bit counted);
      in_valid = 1'b1;
      in_first = first;
      for (int k = 0; k < 5; k++)
         for (int j = 0; j < LANES; j++)
            diff_in[(k*LANES+j)*8 +: 8] = 8'(ln[k][j]);
      check("in_ready_line", in_ready, 1);
      step();
      in_valid = 1'b0;
      in_first = 1'b0;
      if (counted) model_line(first);
   endtask

   task automatic get_result(input int hold);
      int lat = 0;
      int ei;
      int es;
      logic [2:0]       hi;
      logic [SAD_W-1:0] hs;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check("latency", lat, 5);
      exp_best(ei, es);
      check("best_idx", best_idx, ei);
      check("best_sad", best_sad, es);
      hi = best_idx;
      hs = best_sad;
      out_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
         in_valid = 1'b1;
         in_first = 1'b1;
         check("done_ready", in_ready, 0);
         step();
         check("hold_valid", out_valid, 1);
         check("hold_idx", best_idx, hi);
         check("hold_sad", best_sad, hs);
      end
      in_valid  = 1'b0;
      in_first  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("valid_clr", out_valid, 0);
      check("ready_after", in_ready, 1);
   endtask

   task automatic block_const(input int a0, input int a1, input int a2, input int a3, input int a4);
      fill(a0, a1, a2, a3, a4);
      send_line(1'b1, 1'b1);
      for (int l = 1; l < LINES; l++) send_line(1'b0, 1'b1);
   endtask

   initial begin
      int ei;
      int es;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      diff_in   = '0;
      out_ready = 1'b0;
      step();
      step();
      check("rst_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_idx", best_idx, 0);
      check("rst_sad", best_sad, 0);
      rst = 1'b0;
      #1;
      check("idle_ready", in_ready, 1);

      block_const(1, 2, 3, 4, 5);
      get_result(0);
      check("ramp_sad", best_sad, 56);

      block_const(255, 255, 255, 255, 255);
      get_result(0);
      check("ff_sad", best_sad, 14280);

      block_const(9, 9, 9, 1, 9);
      get_result(10);

      fill_rand(255);
      send_line(1'b1, 1'b1);
      for (int l = 0; l < 3; l++) begin
         fill_rand(255);
         send_line(1'b0, 1'b1);
      end
      block_const(2, 2, 2, 2, 2);
      get_result(0);
      check("restart_sad", best_sad, 112);

      fill_rand(255);
      send_line(1'b1, 1'b1);
      for (int l = 0; l < 4; l++) begin
         fill_rand(255);
         send_line(1'b0, 1'b1);
      end
      in_valid = 1'b1;
      rst      = 1'b1;
      #1;
      check("rst_mid_ready", in_ready, 0);
      step();
      in_valid = 1'b0;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_idx", best_idx, 0);
      check("rst_mid_sad", best_sad, 0);
      rst = 1'b0;
      #1;
      fill(0, 0, 0, 0, 0);
      ln[1][0] = 200;
      send_line(1'b0, 1'b0);
      fill_rand(255);
      send_line(1'b1, 1'b1);
      for (int l = 1; l < LINES; l++) begin
         fill_rand(255);
         send_line(1'b0, 1'b1);
      end
      get_result(1);

      for (int b = 0; b < 30; b++) begin
         int mx;
         mx = (b % 2 == 1) ? 2 : 255;
         fill_rand(mx);
         send_line(1'b1, 1'b1);
         for (int l = 1; l < LINES; l++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step();
            fill_rand(mx);
            if (b % 5 == 0) ln[2] = ln[0];
            send_line(1'b0, 1'b1);
         end
         get_result($urandom_range(0, 3));
      end

      exp_best(ei, es);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got 1 expected 0");
      $fatal(1, "timeout");
   end

endmodule
